// File: rtl/core_pkg.sv
// Shared trap-controller constants: CSR map, cause codes, mtvec modes, FSM states.
package core_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned CSR_AW = 12;
  localparam int unsigned CNT_W  = 4;

  localparam logic [CSR_AW-1:0] CSR_MSTATUS = 12'h300;
  localparam logic [CSR_AW-1:0] CSR_MIE     = 12'h304;
  localparam logic [CSR_AW-1:0] CSR_MTVEC   = 12'h305;
  localparam logic [CSR_AW-1:0] CSR_MEPC    = 12'h341;
  localparam logic [CSR_AW-1:0] CSR_MCAUSE  = 12'h342;
  localparam logic [CSR_AW-1:0] CSR_MIP     = 12'h344;

  localparam int unsigned MSTATUS_MIE_BIT  = 3;
  localparam int unsigned MSTATUS_MPIE_BIT = 7;
  localparam int unsigned MEIE_BIT         = 11;

  localparam logic [XLEN-1:0] ILLEGAL_INSN   = 32'd2;
  localparam logic [XLEN-1:0] M_EXT_IRQ      = 32'h8000_000B;
  localparam logic [XLEN-1:0] IRQ_VEC_OFFSET = 32'h0000_002C;

  localparam logic [1:0] MTVEC_DIRECT   = 2'd0;
  localparam logic [1:0] MTVEC_VECTORED = 2'd1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FLUSH,
    ST_REDIRECT
  } trap_state_e;

endpackage

// File: rtl/trap_unit_if.sv
// Commit-side / fetch-side signal bundle for the trap controller.
interface trap_unit_if;
  import core_pkg::*;

  logic [XLEN-1:0]   pc_exc;
  logic [XLEN-1:0]   cause;
  logic              exception_pending;
  logic              mret;
  logic              sret;
  logic              uret;
  logic [XLEN-1:0]   csr_wb;
  logic [CSR_AW-1:0] csr_wb_addr;
  logic              csr_we;
  logic              irq_ext;
  logic [CSR_AW-1:0] csr_raddr;
  logic [XLEN-1:0]   csr_rdata;
  logic              flush;
  logic              redirect_valid;
  logic [XLEN-1:0]   redirect_pc;
  logic              busy;

  modport master (
    output pc_exc, cause, exception_pending, mret, sret, uret,
           csr_wb, csr_wb_addr, csr_we, irq_ext, csr_raddr,
    input  csr_rdata, flush, redirect_valid, redirect_pc, busy
  );

  modport slave (
    input  pc_exc, cause, exception_pending, mret, sret, uret,
           csr_wb, csr_wb_addr, csr_we, irq_ext, csr_raddr,
    output csr_rdata, flush, redirect_valid, redirect_pc, busy
  );

endinterface

// File: rtl/trap_csr_file.sv
// Trap CSR storage: write masking, trap/return side effects, read mux with mip.
module trap_csr_file import core_pkg::*; #(
  parameter logic [XLEN-1:0] RESET_MTVEC = 32'h0000_0100
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              csr_we_i,
  input  logic [CSR_AW-1:0] csr_waddr_i,
  input  logic [XLEN-1:0]   csr_wdata_i,
  input  logic              trap_enter_i,
  input  logic              mret_i,
  input  logic [XLEN-1:0]   trap_mepc_i,
  input  logic [XLEN-1:0]   trap_mcause_i,
  input  logic              irq_ext_i,
  input  logic [CSR_AW-1:0] csr_raddr_i,
  output logic [XLEN-1:0]   csr_rdata_c_o,
  output logic              mie_o,
  output logic              meie_o,
  output logic [XLEN-1:0]   mtvec_o,
  output logic [XLEN-1:0]   mepc_o
);

  localparam logic [XLEN-1:0] ALIGN_MASK = 32'hFFFF_FFFC;

  logic            mie_q, mie_d;
  logic            mpie_q, mpie_d;
  logic            meie_q, meie_d;
  logic [XLEN-1:0] mtvec_q, mtvec_d;
  logic [XLEN-1:0] mepc_q, mepc_d;
  logic [XLEN-1:0] mcause_q, mcause_d;

  // Next-state: trap entry beats mret beats a software CSR write.
  always_comb begin
    mie_d    = mie_q;
    mpie_d   = mpie_q;
    meie_d   = meie_q;
    mtvec_d  = mtvec_q;
    mepc_d   = mepc_q;
    mcause_d = mcause_q;
    if (trap_enter_i) begin
      mpie_d   = mie_q;
      mie_d    = 1'b0;
      mepc_d   = trap_mepc_i & ALIGN_MASK;
      mcause_d = trap_mcause_i;
    end else if (mret_i) begin
      mie_d  = mpie_q;
      mpie_d = 1'b1;
    end else if (csr_we_i) begin
      case (csr_waddr_i)
        CSR_MSTATUS: begin
          mie_d  = csr_wdata_i[MSTATUS_MIE_BIT];
          mpie_d = csr_wdata_i[MSTATUS_MPIE_BIT];
        end
        CSR_MIE:    meie_d   = csr_wdata_i[MEIE_BIT];
        CSR_MTVEC:  mtvec_d  = {csr_wdata_i[XLEN-1:2],
                                (csr_wdata_i[1:0] == MTVEC_VECTORED) ? MTVEC_VECTORED : MTVEC_DIRECT};
        CSR_MEPC:   mepc_d   = csr_wdata_i & ALIGN_MASK;
        CSR_MCAUSE: mcause_d = csr_wdata_i;
        default: ;
      endcase
    end
  end

  // CSR registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mie_q    <= 1'b0;
      mpie_q   <= 1'b0;
      meie_q   <= 1'b0;
      mtvec_q  <= RESET_MTVEC;
      mepc_q   <= '0;
      mcause_q <= '0;
    end else begin
      mie_q    <= mie_d;
      mpie_q   <= mpie_d;
      meie_q   <= meie_d;
      mtvec_q  <= mtvec_d;
      mepc_q   <= mepc_d;
      mcause_q <= mcause_d;
    end
  end

  // Read mux; unimplemented addresses read zero.
  always_comb begin
    csr_rdata_c_o = '0;
    case (csr_raddr_i)
      CSR_MSTATUS: begin
        csr_rdata_c_o[MSTATUS_MIE_BIT]  = mie_q;
        csr_rdata_c_o[MSTATUS_MPIE_BIT] = mpie_q;
      end
      CSR_MIE:    csr_rdata_c_o[MEIE_BIT] = meie_q;
      CSR_MTVEC:  csr_rdata_c_o = mtvec_q;
      CSR_MEPC:   csr_rdata_c_o = mepc_q;
      CSR_MCAUSE: csr_rdata_c_o = mcause_q;
      CSR_MIP:    csr_rdata_c_o[MEIE_BIT] = irq_ext_i;
      default: ;
    endcase
  end

  assign mie_o   = mie_q;
  assign meie_o  = meie_q;
  assign mtvec_o = mtvec_q;
  assign mepc_o  = mepc_q;

endmodule

// File: rtl/trap_unit.sv
// Machine-mode trap controller: event priority, target selection, flush/redirect FSM.
module trap_unit import core_pkg::*; #(
  parameter int unsigned     FLUSH_CYCLES = 2,
  parameter logic [XLEN-1:0] RESET_MTVEC  = 32'h0000_0100
) (
  input  logic       clk,
  input  logic       rst,
  trap_unit_if.slave bus
);

  trap_state_e       state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [XLEN-1:0]   redirect_pc_q, redirect_pc_d;
  logic              flush_q, flush_d;
  logic              redirect_valid_q, redirect_valid_d;
  logic              busy_q, busy_d;

  logic              trap_enter_c;
  logic              mret_c;
  logic              csr_we_c;
  logic [XLEN-1:0]   trap_mepc_c;
  logic [XLEN-1:0]   trap_mcause_c;
  logic              irq_take_c;
  logic [XLEN-1:0]   trap_base_c;
  logic [XLEN-1:0]   csr_rdata_c;
  logic              mie;
  logic              meie;
  logic [XLEN-1:0]   mtvec;
  logic [XLEN-1:0]   mepc;

  trap_csr_file #(.RESET_MTVEC(RESET_MTVEC)) u_csr (
    .clk           (clk),
    .rst           (rst),
    .csr_we_i      (csr_we_c),
    .csr_waddr_i   (bus.csr_wb_addr),
    .csr_wdata_i   (bus.csr_wb),
    .trap_enter_i  (trap_enter_c),
    .mret_i        (mret_c),
    .trap_mepc_i   (trap_mepc_c),
    .trap_mcause_i (trap_mcause_c),
    .irq_ext_i     (bus.irq_ext),
    .csr_raddr_i   (bus.csr_raddr),
    .csr_rdata_c_o (csr_rdata_c),
    .mie_o         (mie),
    .meie_o        (meie),
    .mtvec_o       (mtvec),
    .mepc_o        (mepc)
  );

  // Event decode in IDLE and flush/redirect sequencing.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    redirect_pc_d = redirect_pc_q;
    trap_enter_c  = 1'b0;
    mret_c        = 1'b0;
    csr_we_c      = 1'b0;
    trap_mepc_c   = bus.pc_exc;
    trap_mcause_c = bus.cause;
    irq_take_c    = mie & meie & bus.irq_ext;
    trap_base_c   = {mtvec[XLEN-1:2], 2'b00};
    case (state_q)
      ST_IDLE: begin
        if (bus.exception_pending) begin
          trap_enter_c  = 1'b1;
          redirect_pc_d = trap_base_c;
        end else if (bus.sret || bus.uret) begin
          trap_enter_c  = 1'b1;
          trap_mcause_c = ILLEGAL_INSN;
          redirect_pc_d = trap_base_c;
        end else if (bus.mret) begin
          mret_c        = 1'b1;
          redirect_pc_d = mepc;
        end else if (irq_take_c) begin
          trap_enter_c  = 1'b1;
          trap_mepc_c   = bus.pc_exc + 32'd4;
          trap_mcause_c = M_EXT_IRQ;
          redirect_pc_d = (mtvec[1:0] == MTVEC_VECTORED) ? trap_base_c + IRQ_VEC_OFFSET
                                                         : trap_base_c;
        end else begin
          csr_we_c = bus.csr_we;
        end
        if (trap_enter_c || mret_c) begin
          state_d = ST_FLUSH;
          cnt_d   = CNT_W'(FLUSH_CYCLES - 1);
        end
      end
      ST_FLUSH: begin
        if (cnt_q == '0) state_d = ST_REDIRECT;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      ST_REDIRECT: state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
    flush_d          = (state_d == ST_FLUSH);
    redirect_valid_d = (state_d == ST_REDIRECT);
    busy_d           = (state_d != ST_IDLE);
  end

  // FSM state, counter, target and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q          <= ST_IDLE;
      cnt_q            <= '0;
      redirect_pc_q    <= '0;
      flush_q          <= 1'b0;
      redirect_valid_q <= 1'b0;
      busy_q           <= 1'b0;
    end else begin
      state_q          <= state_d;
      cnt_q            <= cnt_d;
      redirect_pc_q    <= redirect_pc_d;
      flush_q          <= flush_d;
      redirect_valid_q <= redirect_valid_d;
      busy_q           <= busy_d;
    end
  end

  assign bus.csr_rdata      = csr_rdata_c;
  assign bus.flush          = flush_q;
  assign bus.redirect_valid = redirect_valid_q;
  assign bus.redirect_pc    = redirect_pc_q;
  assign bus.busy           = busy_q;

endmodule

// File: tb/tb_trap_unit.sv
// Randomized bench for trap_unit against a transaction-level CSR/trap model.
module tb_trap_unit;

  localparam int unsigned FC = 2;

  logic clk = 1'b0;
  logic rst;
  always #10 clk = ~clk;

  trap_unit_if bus();

  trap_unit #(.FLUSH_CYCLES(FC), .RESET_MTVEC(32'h0000_0100)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Architectural model state.
  logic        m_mie, m_mpie, m_meie;
  logic [31:0] m_mtvec, m_mepc, m_mcause;

  logic [11:0] addr_list [8] = '{12'h300, 12'h304, 12'h305, 12'h341,
                                 12'h342, 12'h344, 12'h000, 12'h301};

  task automatic check32(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_mie = 1'b0; m_mpie = 1'b0; m_meie = 1'b0;
    m_mtvec = 32'h0000_0100; m_mepc = 32'h0; m_mcause = 32'h0;
  endtask

  task automatic model_write(input logic [11:0] a, input logic [31:0] d);
    case (a)
      12'h300: begin m_mie = d[3]; m_mpie = d[7]; end
      12'h304: m_meie = d[11];
      12'h305: m_mtvec = {d[31:2], (d[1:0] == 2'b01) ? 2'b01 : 2'b00};
      12'h341: m_mepc = d & 32'hFFFF_FFFC;
      12'h342: m_mcause = d;
      default: ;
    endcase
  endtask

  function automatic logic [31:0] model_read(input logic [11:0] a, input logic irq);
    logic [31:0] v;
    v = 32'h0;
    case (a)
      12'h300: begin v[3] = m_mie; v[7] = m_mpie; end
      12'h304: v[11] = m_meie;
      12'h305: v = m_mtvec;
      12'h341: v = m_mepc;
      12'h342: v = m_mcause;
      12'h344: v[11] = irq;
      default: ;
    endcase
    return v;
  endfunction

  task automatic drive_quiet();
    bus.pc_exc = 32'h0; bus.cause = 32'h0; bus.exception_pending = 1'b0;
    bus.mret = 1'b0; bus.sret = 1'b0; bus.uret = 1'b0;
    bus.csr_wb = 32'h0; bus.csr_wb_addr = 12'h0; bus.csr_we = 1'b0;
    bus.irq_ext = 1'b0; bus.csr_raddr = 12'h0;
  endtask

  // Junk that must be ignored while the unit is busy.
  task automatic drive_garbage();
    bus.pc_exc = $urandom; bus.cause = $urandom;
    bus.exception_pending = 1'($urandom); bus.mret = 1'($urandom);
    bus.sret = 1'($urandom); bus.uret = 1'($urandom);
    bus.csr_we = 1'b1; bus.csr_wb = $urandom;
    bus.csr_wb_addr = addr_list[$urandom_range(0, 7)];
    bus.irq_ext = 1'($urandom);
  endtask

  task automatic cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic read_expect(input string tag, input logic [11:0] a, input logic [31:0] exp);
    bus.csr_raddr = a;
    #1;
    check32(tag, bus.csr_rdata, exp);
  endtask

  task automatic check_csrs();
    bus.irq_ext = 1'($urandom);
    for (int i = 0; i < 8; i++) begin
      bus.csr_raddr = addr_list[i];
      #1;
      check32($sformatf("csr_%03h", addr_list[i]), bus.csr_rdata,
              model_read(addr_list[i], bus.irq_ext));
    end
  endtask

  // One IDLE cycle of commit input, followed by the full flush/redirect sequence if it is an event.
  task automatic issue(input logic exc, input logic sr, input logic ur, input logic mr,
                       input logic irq, input logic we, input logic [11:0] wa,
                       input logic [31:0] wd, input logic [31:0] pc, input logic [31:0] cs,
                       output logic [31:0] rpc_seen);
    int          ev;
    logic [31:0] exp_pc;
    logic [31:0] base;
    bus.exception_pending = exc; bus.sret = sr; bus.uret = ur; bus.mret = mr;
    bus.irq_ext = irq; bus.csr_we = we; bus.csr_wb_addr = wa; bus.csr_wb = wd;
    bus.pc_exc = pc; bus.cause = cs;
    base   = m_mtvec & 32'hFFFF_FFFC;
    exp_pc = 32'h0;
    ev     = 0;
    if (exc)                            ev = 1;
    else if (sr || ur)                  ev = 2;
    else if (mr)                        ev = 3;
    else if (m_mie && m_meie && irq)    ev = 4;
    case (ev)
      1, 2, 4: begin
        m_mpie   = m_mie;
        m_mie    = 1'b0;
        m_mepc   = ((ev == 4) ? pc + 32'd4 : pc) & 32'hFFFF_FFFC;
        m_mcause = (ev == 1) ? cs : (ev == 2) ? 32'd2 : 32'h8000_000B;
        exp_pc   = (ev == 4 && m_mtvec[1:0] == 2'b01) ? base + 32'h2C : base;
      end
      3: begin
        exp_pc = m_mepc;
        m_mie  = m_mpie;
        m_mpie = 1'b1;
      end
      default: if (we) model_write(wa, wd);
    endcase
    cycle();
    rpc_seen = bus.redirect_pc;
    if (ev == 0) begin
      check32("idle_flush", 32'(bus.flush), 32'h0);
      check32("idle_busy", 32'(bus.busy), 32'h0);
      check32("idle_rv", 32'(bus.redirect_valid), 32'h0);
    end else begin
      for (int i = 0; i < int'(FC); i++) begin
        check32("flush_hi", 32'(bus.flush), 32'h1);
        check32("flush_busy", 32'(bus.busy), 32'h1);
        check32("flush_rv", 32'(bus.redirect_valid), 32'h0);
        check32("flush_rpc", bus.redirect_pc, exp_pc);
        drive_garbage();
        cycle();
      end
      rpc_seen = bus.redirect_pc;
      check32("redir_rv", 32'(bus.redirect_valid), 32'h1);
      check32("redir_flush", 32'(bus.flush), 32'h0);
      check32("redir_busy", 32'(bus.busy), 32'h1);
      check32("redir_pc", bus.redirect_pc, exp_pc);
      drive_garbage();
      cycle();
      check32("post_busy", 32'(bus.busy), 32'h0);
      check32("post_rv", 32'(bus.redirect_valid), 32'h0);
      check32("post_flush", 32'(bus.flush), 32'h0);
    end
    drive_quiet();
  endtask

  initial begin
    logic [31:0] rpc;
    rst = 1'b1;
    drive_quiet();
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    cycle();

    // Reset state.
    check32("rst_flush", 32'(bus.flush), 32'h0);
    check32("rst_rv", 32'(bus.redirect_valid), 32'h0);
    check32("rst_busy", 32'(bus.busy), 32'h0);
    check32("rst_rpc", bus.redirect_pc, 32'h0);
    read_expect("rst_mtvec", 12'h305, 32'h0000_0100);
    check_csrs();

    // Synchronous exception in direct mode.
    issue(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 12'h0, 32'h0, 32'h2000, 32'd5, rpc);
    check32("tp_exc_target", rpc, 32'h0000_0100);
    read_expect("tp_exc_mepc", 12'h341, 32'h2000);
    read_expect("tp_exc_mcause", 12'h342, 32'd5);
    read_expect("tp_exc_mstatus", 12'h300, 32'h0);

    // Vectored external interrupt.
    issue(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 12'h305, 32'h401, 32'h0, 32'h0, rpc);
    issue(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 12'h304, 32'h800, 32'h0, 32'h0, rpc);
    issue(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 12'h300, 32'h8, 32'h0, 32'h0, rpc);
    read_expect("tp_mtvec_wr", 12'h305, 32'h401);
    issue(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 12'h0, 32'h0, 32'h3000, 32'h0, rpc);
    check32("tp_irq_target", rpc, 32'h0000_042C);
    read_expect("tp_irq_mepc", 12'h341, 32'h3004);
    read_expect("tp_irq_mcause", 12'h342, 32'h8000_000B);
    read_expect("tp_irq_mstatus", 12'h300, 32'h80);

    // Return from the interrupt handler.
    issue(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 12'h0, 32'h0, 32'h0, 32'h0, rpc);
    check32("tp_mret_target", rpc, 32'h3004);
    read_expect("tp_mret_mstatus", 12'h300, 32'h88);

    // CSR write colliding with an exception is dropped; sret is illegal.
    issue(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 12'h341, 32'hDEAD_0000, 32'h5000, 32'd7, rpc);
    check32("tp_coll_target", rpc, 32'h0000_0400);
    read_expect("tp_coll_mepc", 12'h341, 32'h5000);
    issue(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 12'h0, 32'h0, 32'h6000, 32'd9, rpc);
    read_expect("tp_sret_mcause", 12'h342, 32'd2);
    read_expect("tp_sret_mepc", 12'h341, 32'h6000);
    check_csrs();

    // Reset in the middle of a flush.
    bus.exception_pending = 1'b1; bus.pc_exc = 32'h7000; bus.cause = 32'd3;
    cycle();
    drive_quiet();
    check32("mid_flush_pre", 32'(bus.flush), 32'h1);
    rst = 1'b1;
    #1;
    check32("mid_rst_flush", 32'(bus.flush), 32'h0);
    check32("mid_rst_rv", 32'(bus.redirect_valid), 32'h0);
    check32("mid_rst_busy", 32'(bus.busy), 32'h0);
    for (int i = 0; i < 3; i++) begin
      cycle();
      check32("mid_rst_rv_hold", 32'(bus.redirect_valid), 32'h0);
    end
    rst = 1'b0;
    model_reset();
    read_expect("mid_rst_mtvec", 12'h305, 32'h0000_0100);
    check_csrs();
    cycle();
    check32("mid_rst_idle_rv", 32'(bus.redirect_valid), 32'h0);
    check32("mid_rst_idle_busy", 32'(bus.busy), 32'h0);

    // Randomized traffic.
    for (int n = 0; n < 400; n++) begin
      logic        r_exc, r_sr, r_ur, r_mr, r_irq, r_we;
      logic [11:0] r_wa;
      logic [31:0] r_wd, r_pc;
      r_exc = ($urandom_range(0, 7) == 0);
      r_sr  = ($urandom_range(0, 15) == 0);
      r_ur  = ($urandom_range(0, 15) == 0);
      r_mr  = ($urandom_range(0, 7) == 0);
      r_irq = ($urandom_range(0, 2) == 0);
      r_we  = 1'($urandom);
      r_wa  = addr_list[$urandom_range(0, 7)];
      r_wd  = $urandom;
      r_pc  = $urandom;
      issue(r_exc, r_sr, r_ur, r_mr, r_irq, r_we, r_wa, r_wd, r_pc, $urandom, rpc);
      check_csrs();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
